core_seq_mc: RTL and testbench

//  Multi-cycle sequencer for the RV32 core: owns the PC, fetches via a valid/ready IFU port,

---
 rtl/core_seq_mc_if.sv | 23 ++
 rtl/core_seq_mc.sv | 128 ++++++++++++
 tb/tb_core_seq_mc.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_seq_mc_if.sv
// Fetch (IFU) and memory (LSU) handshake bundle between the sequencer and its memory side.
interface core_seq_mc_if #(
    parameter int XLEN = 32
);
    logic            ifu_req_valid;
    logic            ifu_req_ready;
    logic [XLEN-1:0] ifu_req_addr;
    logic            ifu_rsp_valid;
    logic [31:0]     ifu_rsp_inst;
    logic            lsu_req_valid;
    logic            lsu_req_ready;
    logic            lsu_rsp_valid;

    modport master (
        output ifu_req_valid, ifu_req_addr, lsu_req_valid,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst, lsu_req_ready, lsu_rsp_valid
    );

    modport slave (
        input  ifu_req_valid, ifu_req_addr, lsu_req_valid,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst, lsu_req_ready, lsu_rsp_valid
    );
endinterface

// File: rtl/core_seq_mc.sv
// Multi-cycle RV32 sequencer: owns the PC, fetches, waits on memory, commits and halts on
// ecall/ebreak or a misaligned jump target.
module core_seq_mc #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    core_seq_mc_if.master    bus,
    output logic [31:0]      inst_o,
    output logic [XLEN-1:0]  pc_o,
    input  logic [XLEN-1:0]  exu_upc_i,
    input  logic             exu_jump_i,
    input  logic             exu_reg_wen_i,
    input  logic             exu_is_mem_i,
    output logic             rf_wen_o,
    output logic             retire_o,
    output logic [CNT_W-1:0] retire_cnt_o,
    output logic             halted_o,
    output logic             fault_o
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] F_REQ  = 3'd1;
    localparam logic [2:0] F_WAIT = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] M_REQ  = 3'd4;
    localparam logic [2:0] M_WAIT = 3'd5;
    localparam logic [2:0] WB     = 3'd6;
    localparam logic [2:0] HALT   = 3'd7;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [2:0]       state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [31:0]      inst_q, inst_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halted_q, halted_d;
    logic             fault_q, fault_d;

    logic             isSystemHalt;
    logic             misJump;
    logic             wbCommit;
    logic [XLEN-1:0]  target;

    // ecall/ebreak both decode as SYSTEM with func3 = 0
    assign isSystemHalt = (inst_q[6:0] == 7'b1110011) && (inst_q[14:12] == 3'b000);
    assign misJump      = exu_jump_i && (exu_upc_i[1:0] != 2'b00);
    assign target       = exu_jump_i ? exu_upc_i : pc_q + {{(XLEN-3){1'b0}}, 3'd4};
    assign wbCommit     = (state_q == WB) && !misJump;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        cnt_d    = cnt_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        case (state_q)
            IDLE:   if (run_i) state_d = F_REQ;
            F_REQ:  if (bus.ifu_req_ready) state_d = F_WAIT;
            F_WAIT: begin
                if (bus.ifu_rsp_valid) begin
                    inst_d  = bus.ifu_rsp_inst;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (isSystemHalt) begin
                    cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    halted_d = 1'b1;
                    state_d  = HALT;
                end else if (exu_is_mem_i) begin
                    state_d = M_REQ;
                end else begin
                    state_d = WB;
                end
            end
            M_REQ:  if (bus.lsu_req_ready) state_d = M_WAIT;
            M_WAIT: if (bus.lsu_rsp_valid) state_d = WB;
            WB: begin
                // A misaligned target faults without committing; pc keeps the jump's address
                if (misJump) begin
                    fault_d  = 1'b1;
                    halted_d = 1'b1;
                    state_d  = HALT;
                end else begin
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    pc_d    = target;
                    state_d = run_i ? F_REQ : IDLE;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            inst_q   <= NOP;
            cnt_q    <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    assign bus.ifu_req_valid = (state_q == F_REQ);
    assign bus.ifu_req_addr  = pc_q;
    assign bus.lsu_req_valid = (state_q == M_REQ);

    assign inst_o       = inst_q;
    assign pc_o         = pc_q;
    assign rf_wen_o     = wbCommit && exu_reg_wen_i;
    assign retire_o     = wbCommit || ((state_q == EXEC) && isSystemHalt);
    assign retire_cnt_o = cnt_q;
    assign halted_o     = halted_q;
    assign fault_o      = fault_q;
endmodule

// File: tb/tb_core_seq_mc.sv
// Directed bench for core_seq_mc: the bench plays IFU, LSU and EXU and checks every step
// against hand-computed values.
module tb_core_seq_mc;
    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] exuUpc;
    logic        exuJump;
    logic        exuRegWen;
    logic        exuIsMem;
    logic        rfWen;
    logic        retire;
    logic [31:0] retireCnt;
    logic        halted;
    logic        fault;

    int compareCount = 0;
    int failCount    = 0;
    int rfWenCount   = 0;
    int lsuValidCount = 0;
    int cycles;
    int ifuSeen;

    core_seq_mc_if #(.XLEN(32)) bus ();

    core_seq_mc dut (
        .clk          (clk),
        .rst          (rst),
        .run_i        (run),
        .bus          (bus),
        .inst_o       (inst),
        .pc_o         (pc),
        .exu_upc_i    (exuUpc),
        .exu_jump_i   (exuJump),
        .exu_reg_wen_i(exuRegWen),
        .exu_is_mem_i (exuIsMem),
        .rf_wen_o     (rfWen),
        .retire_o     (retire),
        .retire_cnt_o (retireCnt),
        .halted_o     (halted),
        .fault_o      (fault)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the active edge, i.e. the cycles the pulses were really seen
    always @(posedge clk) begin
        if (rfWen === 1'b1) rfWenCount++;
        if (bus.lsu_req_valid === 1'b1) lsuValidCount++;
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] upc, input logic jump, input logic regWen, input logic isMem);
        exuUpc    = upc;
        exuJump   = jump;
        exuRegWen = regWen;
        exuIsMem  = isMem;
    endtask

    // Zero-wait fetch from IDLE/WB with run=1; returns at the negedge of the EXEC cycle
    task automatic fetchZeroWait(input logic [31:0] word);
        bus.ifu_req_ready = 1'b1;
        cyc();
        cyc();
        bus.ifu_rsp_valid = 1'b1;
        bus.ifu_rsp_inst  = word;
        cyc();
        bus.ifu_rsp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        bus.ifu_req_ready = 1'b0;
        bus.ifu_rsp_valid = 1'b0;
        bus.ifu_rsp_inst  = 32'h0;
        bus.lsu_req_ready = 1'b0;
        bus.lsu_rsp_valid = 1'b0;
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) cyc();

        $display("[TB] reset state");
        checkOutput("rst_pc",        pc,                        32'h8000_0000);
        checkOutput("rst_inst",      inst,                      32'h0000_0013);
        checkOutput("rst_cnt",       retireCnt,                 32'd0);
        checkOutput("rst_halted",    32'(halted),               32'd0);
        checkOutput("rst_fault",     32'(fault),                32'd0);
        checkOutput("rst_ifu_valid", 32'(bus.ifu_req_valid),    32'd0);
        checkOutput("rst_rf_wen",    32'(rfWen),                32'd0);
        checkOutput("rst_retire",    32'(retire),               32'd0);

        $display("[TB] test 1: addi x1,x0,5 zero-wait");
        rst = 1'b0;
        run = 1'b1;
        bus.ifu_req_ready = 1'b1;
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
        cyc();
        checkOutput("t1_req_valid", 32'(bus.ifu_req_valid), 32'd1);
        checkOutput("t1_req_addr",  bus.ifu_req_addr,       32'h8000_0000);
        cyc();
        checkOutput("t1_fwait_valid", 32'(bus.ifu_req_valid), 32'd0);
        bus.ifu_rsp_valid = 1'b1;
        bus.ifu_rsp_inst  = 32'h0050_0093;
        cyc();
        bus.ifu_rsp_valid = 1'b0;
        checkOutput("t1_exec_inst",   inst,         32'h0050_0093);
        checkOutput("t1_exec_rf_wen", 32'(rfWen),   32'd0);
        checkOutput("t1_exec_retire", 32'(retire),  32'd0);
        cyc();
        checkOutput("t1_wb_rf_wen", 32'(rfWen),  32'd1);
        checkOutput("t1_wb_retire", 32'(retire), 32'd1);
        run = 1'b0;
        cyc();
        checkOutput("t1_pc",       pc,                     32'h8000_0004);
        checkOutput("t1_cnt",      retireCnt,              32'd1);
        checkOutput("t1_rf_pulse", 32'(rfWen),             32'd0);
        cyc();
        checkOutput("t1_idle_stop", 32'(bus.ifu_req_valid), 32'd0);

        $display("[TB] test 2: IFU ready +3, rsp +2");
        run = 1'b1;
        bus.ifu_req_ready = 1'b0;
        cycles = 0;
        cyc(); cycles++;
        for (int i = 0; i < 3; i++) begin
            checkOutput("t2_req_valid", 32'(bus.ifu_req_valid), 32'd1);
            checkOutput("t2_req_addr",  bus.ifu_req_addr,       32'h8000_0004);
            cyc(); cycles++;
        end
        checkOutput("t2_req_valid_acc", 32'(bus.ifu_req_valid), 32'd1);
        checkOutput("t2_req_addr_acc",  bus.ifu_req_addr,       32'h8000_0004);
        bus.ifu_req_ready = 1'b1;
        cyc(); cycles++;
        checkOutput("t2_fwait_valid", 32'(bus.ifu_req_valid), 32'd0);
        cyc(); cycles++;
        checkOutput("t2_fwait_inst", inst, 32'h0050_0093);
        cyc(); cycles++;
        bus.ifu_rsp_valid = 1'b1;
        bus.ifu_rsp_inst  = 32'h00a0_0113;
        cyc(); cycles++;
        bus.ifu_rsp_valid = 1'b0;
        checkOutput("t2_exec_rf_wen", 32'(rfWen), 32'd0);
        cyc(); cycles++;
        checkOutput("t2_wb_rf_wen", 32'(rfWen), 32'd1);
        checkOutput("t2_latency",   32'(cycles), 32'd9);
        run = 1'b0;
        cyc();
        checkOutput("t2_pc",       pc,               32'h8000_0008);
        checkOutput("t2_cnt",      retireCnt,        32'd2);
        checkOutput("t2_rf_count", 32'(rfWenCount),  32'd2);

        $display("[TB] test 3: lw with LSU wait states");
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b1);
        run = 1'b1;
        lsuValidCount = 0;
        fetchZeroWait(32'h0000_a183);
        checkOutput("t3_exec_lsu_valid", 32'(bus.lsu_req_valid), 32'd0);
        cyc();
        checkOutput("t3_mreq1_valid", 32'(bus.lsu_req_valid), 32'd1);
        cyc();
        checkOutput("t3_mreq2_valid", 32'(bus.lsu_req_valid), 32'd1);
        cyc();
        checkOutput("t3_mreq3_valid", 32'(bus.lsu_req_valid), 32'd1);
        bus.lsu_req_ready = 1'b1;
        cyc();
        bus.lsu_req_ready = 1'b0;
        checkOutput("t3_mwait_valid",  32'(bus.lsu_req_valid), 32'd0);
        checkOutput("t3_mwait_rf_wen", 32'(rfWen),             32'd0);
        bus.lsu_rsp_valid = 1'b1;
        cyc();
        bus.lsu_rsp_valid = 1'b0;
        checkOutput("t3_wb_rf_wen", 32'(rfWen),  32'd1);
        checkOutput("t3_wb_retire", 32'(retire), 32'd1);
        run = 1'b0;
        cyc();
        checkOutput("t3_pc",          pc,                 32'h8000_000C);
        checkOutput("t3_cnt",         retireCnt,          32'd3);
        checkOutput("t3_rf_count",    32'(rfWenCount),    32'd3);
        checkOutput("t3_lsu_cycles",  32'(lsuValidCount), 32'd3);

        $display("[TB] test 4: jal aligned then misaligned");
        applyStimulus(32'h8000_0100, 1'b1, 1'b1, 1'b0);
        run = 1'b1;
        fetchZeroWait(32'h0f40_00ef);
        cyc();
        checkOutput("t4_wb_rf_wen", 32'(rfWen), 32'd1);
        run = 1'b0;
        cyc();
        checkOutput("t4_pc",  pc,        32'h8000_0100);
        checkOutput("t4_cnt", retireCnt, 32'd4);
        applyStimulus(32'h8000_0102, 1'b1, 1'b1, 1'b0);
        run = 1'b1;
        fetchZeroWait(32'h0020_00ef);
        cyc();
        checkOutput("t4_mis_rf_wen", 32'(rfWen),  32'd0);
        checkOutput("t4_mis_retire", 32'(retire), 32'd0);
        cyc();
        checkOutput("t4_fault",     32'(fault),             32'd1);
        checkOutput("t4_halted",    32'(halted),            32'd1);
        checkOutput("t4_mis_cnt",   retireCnt,              32'd4);
        checkOutput("t4_mis_pc",    pc,                     32'h8000_0100);
        repeat (3) cyc();
        checkOutput("t4_halt_req",  32'(bus.ifu_req_valid), 32'd0);

        $display("[TB] test 5: ebreak halts");
        rst = 1'b1;
        #1;
        checkOutput("t5_async_pc",     pc,           32'h8000_0000);
        checkOutput("t5_async_fault",  32'(fault),   32'd0);
        checkOutput("t5_async_halted", 32'(halted),  32'd0);
        cyc();
        rst = 1'b0;
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
        run = 1'b1;
        fetchZeroWait(32'h0010_0073);
        checkOutput("t5_exec_retire", 32'(retire), 32'd1);
        checkOutput("t5_exec_rf_wen", 32'(rfWen),  32'd0);
        cyc();
        checkOutput("t5_halted", 32'(halted), 32'd1);
        checkOutput("t5_fault",  32'(fault),  32'd0);
        checkOutput("t5_cnt",    retireCnt,   32'd1);
        checkOutput("t5_pc",     pc,          32'h8000_0000);
        ifuSeen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (bus.ifu_req_valid !== 1'b0) ifuSeen++;
        end
        checkOutput("t5_no_fetch", 32'(ifuSeen), 32'd0);

        $display("[TB] test 6: reset during F_WAIT");
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        run = 1'b1;
        fetchZeroWait(32'h0050_0093);
        cyc();
        cyc();
        checkOutput("t6_fetch2_addr", bus.ifu_req_addr, 32'h8000_0004);
        cyc();
        rst = 1'b1;
        run = 1'b0;
        #1;
        checkOutput("t6_rst_pc",    pc,                     32'h8000_0000);
        checkOutput("t6_rst_inst",  inst,                   32'h0000_0013);
        checkOutput("t6_rst_cnt",   retireCnt,              32'd0);
        checkOutput("t6_rst_valid", 32'(bus.ifu_req_valid), 32'd0);
        cyc();
        rst = 1'b0;
        bus.ifu_rsp_valid = 1'b1;
        bus.ifu_rsp_inst  = 32'hdead_beef;
        repeat (2) cyc();
        bus.ifu_rsp_valid = 1'b0;
        checkOutput("t6_late_inst",  inst,                   32'h0000_0013);
        checkOutput("t6_late_pc",    pc,                     32'h8000_0000);
        checkOutput("t6_late_valid", 32'(bus.ifu_req_valid), 32'd0);
        run = 1'b1;
        cyc();
        checkOutput("t6_restart_valid", 32'(bus.ifu_req_valid), 32'd1);
        checkOutput("t6_restart_addr",  bus.ifu_req_addr,       32'h8000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end
endmodule
